ex_operand_stage: RTL and testbench
===================================

Name: ex_operand_stage

Overview:
- ID/EX pipeline register plus operand-forwarding network directly upstream of the execute-stage ALU.
- Latches decoded instruction fields from decode and resolves RAW hazards by forwarding from the MEM and WB stages.
- Detects load-use hazards and drives the ALU operand/function inputs (a, b, af, i) and the EX/MEM control fields.

Parameters:
- W, 32, datapath width
- RW, 5, register index width

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- stall  in  1  global pipeline stall (memory wait); holds this stage
- flush  in  1  branch/exception flush; kills the instruction being loaded
- id_valid  in  1  decode stage holds a valid instruction
- id_rs_val  in  W  register file read data for rs
- id_rt_val  in  W  register file read data for rt
- id_imm  in  W  immediate, already extended by decode
- id_rs, id_rt, id_rd  in  RW  source/destination indices (id_rd = final write target)
- id_af  in  4  ALU function code
- id_i  in  1  immediate-form flag passed to the ALU
- id_alusrc  in  1  1 = b operand is id_imm
- id_regwrite  in  1  instruction writes the register file
- id_memread  in  1  instruction is a load
- mem_regwrite, mem_rd, mem_result  in  1/RW/W  EX/MEM forwarding source
- wb_regwrite, wb_rd, wb_result  in  1/RW/W  MEM/WB forwarding source
- alu_a, alu_b  out  W  ALU operands
- alu_af  out  4  ALU function
- alu_i  out  1  ALU immediate flag
- ex_store_data  out  W  forwarded rt value for stores
- ex_rd  out  RW  destination index
- ex_regwrite, ex_memread, ex_valid  out  1  EX control
- load_use_hazard  out  1  combinational; decode/fetch must hold when high

Behaviour:
- Reset (async, rst_n=0): all registered fields clear to 0; ex_valid=0, ex_regwrite=0, ex_memread=0, alu_af=0, alu_i=0; alu_a=alu_b=ex_store_data=0 while reset is held. Reset mid-stall or mid-hazard discards the held instruction.
- Load priority each rising edge: stall > flush > load_use_hazard > normal.
  - stall=1: every register holds, including when flush or a hazard is also high. Upstream stages are held by the same signal.
  - flush=1: load a bubble. valid, regwrite and memread become 0; data fields are don't-care but are cleared to 0.
  - load_use_hazard=1: load a bubble, same as flush. Decode re-presents the same instruction the next cycle.
  - otherwise: latch all id_* fields. Registered valid = id_valid. Registered regwrite and memread are ANDed with id_valid.
- A bubble is never forwarded from and never writes; its registered regwrite is 0.
- load_use_hazard = ex_valid & ex_memread & id_valid & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt & ~id_alusrc)).
  - rt is also compared when a store needs rt; stores present id_alusrc=1, so decode ORs a store flag into the rt term externally. This block compares exactly the expression above.
- Forwarding (combinational, from registered rs/rt each cycle, so a held instruction sees current MEM/WB values):
  - fwd_rs = mem_rd==rs & mem_regwrite & rs!=0 ? mem_result : wb_rd==rs & wb_regwrite & rs!=0 ? wb_result : rs_val_reg.
  - fwd_rt follows the same rule.
  - MEM has priority over WB. Register 0 is never forwarded.
- alu_a = fwd_rs. alu_b = alusrc_reg ? imm_reg : fwd_rt. ex_store_data = fwd_rt.
- alu_af and alu_i are the registered values. Outputs are undefined-but-stable when ex_valid=0 and are cleared by a bubble.
- Latency: one cycle from id_* to ALU inputs. Forwarded values arrive in the same cycle as the MEM/WB inputs.
- WB-to-decode same-cycle write-through is the register file's responsibility, not this block's.

Test Plan:
- Reset: rst_n=0 asynchronously mid-cycle with ex_valid=1 -> ex_valid=0, alu_a=alu_b=0 immediately, before the next edge.
- Normal load: id_rs_val=0x10, id_rt_val=0x20, alusrc=0, af=4'b0000, valid=1 -> next cycle alu_a=0x10, alu_b=0x20, alu_af=0, ex_valid=1. Repeat with alusrc=1, imm=0xFFFFFFFC -> alu_b=0xFFFFFFFC.
- Forward priority: registered rs=rt=5; mem_rd=5, mem_result=0xAAAA, wb_rd=5, wb_result=0xBBBB, both regwrite=1 -> alu_a=alu_b=0xAAAA. Drop mem_regwrite -> 0xBBBB. Set rs=0 with the same sources -> the registered value, no forwarding.
- Load-use: EX holds a load with ex_rd=8; decode presents rs=8 -> load_use_hazard=1. Next cycle ex_valid=0, ex_regwrite=0, hazard=0. The re-presented instruction loads on the following edge.
- Stall precedence: stall=1 with flush=1 and new id_* values -> all outputs unchanged. Changing mem_result while stalled updates alu_a if the forward condition holds.
- Flush: flush=1 with valid id_regwrite=1 -> next cycle ex_valid=0, ex_regwrite=0, ex_memread=0, alu_af=0.

Source files
------------

// File: rtl/ex_operand_stage_if.sv
// rtl/ex_operand_stage_if.sv - decode, forwarding and ALU-side signal bundle for the ID/EX operand stage
interface ex_operand_stage_if #(
    parameter int W  = 32,
    parameter int RW = 5
);
    logic          stall;
    logic          flush;
    logic          id_valid;
    logic [W-1:0]  id_rs_val;
    logic [W-1:0]  id_rt_val;
    logic [W-1:0]  id_imm;
    logic [RW-1:0] id_rs;
    logic [RW-1:0] id_rt;
    logic [RW-1:0] id_rd;
    logic [3:0]    id_af;
    logic          id_i;
    logic          id_alusrc;
    logic          id_regwrite;
    logic          id_memread;
    logic          mem_regwrite;
    logic [RW-1:0] mem_rd;
    logic [W-1:0]  mem_result;
    logic          wb_regwrite;
    logic [RW-1:0] wb_rd;
    logic [W-1:0]  wb_result;
    logic [W-1:0]  alu_a;
    logic [W-1:0]  alu_b;
    logic [3:0]    alu_af;
    logic          alu_i;
    logic [W-1:0]  ex_store_data;
    logic [RW-1:0] ex_rd;
    logic          ex_regwrite;
    logic          ex_memread;
    logic          ex_valid;
    logic          load_use_hazard;

    modport master (
        output stall, flush, id_valid, id_rs_val, id_rt_val, id_imm,
               id_rs, id_rt, id_rd, id_af, id_i, id_alusrc, id_regwrite, id_memread,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
        input  alu_a, alu_b, alu_af, alu_i, ex_store_data, ex_rd,
               ex_regwrite, ex_memread, ex_valid, load_use_hazard
    );

    modport slave (
        input  stall, flush, id_valid, id_rs_val, id_rt_val, id_imm,
               id_rs, id_rt, id_rd, id_af, id_i, id_alusrc, id_regwrite, id_memread,
               mem_regwrite, mem_rd, mem_result, wb_regwrite, wb_rd, wb_result,
        output alu_a, alu_b, alu_af, alu_i, ex_store_data, ex_rd,
               ex_regwrite, ex_memread, ex_valid, load_use_hazard
    );
endinterface

// File: rtl/ex_operand_stage.sv
// rtl/ex_operand_stage.sv - ID/EX pipeline register with MEM/WB operand forwarding and load-use detection
module ex_operand_stage #(
    parameter int W  = 32,
    parameter int RW = 5
) (
    input logic               clk,
    input logic               rst_n,
    ex_operand_stage_if.slave bus
);
    logic          valid_q;
    logic          regwrite_q;
    logic          memread_q;
    logic [RW-1:0] rd_q;
    logic [RW-1:0] rs_q;
    logic [RW-1:0] rt_q;
    logic [W-1:0]  rs_val_q;
    logic [W-1:0]  rt_val_q;
    logic [W-1:0]  imm_q;
    logic [3:0]    af_q;
    logic          i_q;
    logic          alusrc_q;

    logic          hazard;
    logic [W-1:0]  fwd_rs;
    logic [W-1:0]  fwd_rt;

    // rt only matters for the hazard when it feeds the b operand
    assign hazard = valid_q & memread_q & bus.id_valid & (rd_q != '0) &
                    ((rd_q == bus.id_rs) | ((rd_q == bus.id_rt) & ~bus.id_alusrc));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            af_q       <= '0;
            i_q        <= 1'b0;
            alusrc_q   <= 1'b0;
        end else if (bus.stall) begin
            valid_q    <= valid_q;
        end else if (bus.flush || hazard) begin
            valid_q    <= 1'b0;
            regwrite_q <= 1'b0;
            memread_q  <= 1'b0;
            rd_q       <= '0;
            rs_q       <= '0;
            rt_q       <= '0;
            rs_val_q   <= '0;
            rt_val_q   <= '0;
            imm_q      <= '0;
            af_q       <= '0;
            i_q        <= 1'b0;
            alusrc_q   <= 1'b0;
        end else begin
            valid_q    <= bus.id_valid;
            regwrite_q <= bus.id_regwrite & bus.id_valid;
            memread_q  <= bus.id_memread & bus.id_valid;
            rd_q       <= bus.id_rd;
            rs_q       <= bus.id_rs;
            rt_q       <= bus.id_rt;
            rs_val_q   <= bus.id_rs_val;
            rt_val_q   <= bus.id_rt_val;
            imm_q      <= bus.id_imm;
            af_q       <= bus.id_af;
            i_q        <= bus.id_i;
            alusrc_q   <= bus.id_alusrc;
        end
    end

    // Forwarding is recomputed every cycle so a stalled instruction tracks live MEM/WB results
    always_comb begin
        fwd_rs = rs_val_q;
        if (rs_q != '0 && bus.mem_regwrite && bus.mem_rd == rs_q)
            fwd_rs = bus.mem_result;
        else if (rs_q != '0 && bus.wb_regwrite && bus.wb_rd == rs_q)
            fwd_rs = bus.wb_result;
    end

    always_comb begin
        fwd_rt = rt_val_q;
        if (rt_q != '0 && bus.mem_regwrite && bus.mem_rd == rt_q)
            fwd_rt = bus.mem_result;
        else if (rt_q != '0 && bus.wb_regwrite && bus.wb_rd == rt_q)
            fwd_rt = bus.wb_result;
    end

    assign bus.alu_a           = fwd_rs;
    assign bus.alu_b           = alusrc_q ? imm_q : fwd_rt;
    assign bus.alu_af          = af_q;
    assign bus.alu_i           = i_q;
    assign bus.ex_store_data   = fwd_rt;
    assign bus.ex_rd           = rd_q;
    assign bus.ex_regwrite     = regwrite_q;
    assign bus.ex_memread      = memread_q;
    assign bus.ex_valid        = valid_q;
    assign bus.load_use_hazard = hazard;
endmodule

// File: tb/tb_ex_operand_stage.sv
// tb/tb_ex_operand_stage.sv - vector table, corner sequences and random checks against an instruction-level model
module tb_ex_operand_stage;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ex_operand_stage_if #(.W(32), .RW(5)) bus ();

    ex_operand_stage #(.W(32), .RW(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic       v, rw, mr;
        logic [4:0] rd, rs, rt;
        logic [31:0] rsv, rtv, imm;
        logic [3:0] af;
        logic       i, src;
    } instr_t;

    typedef struct {
        logic [31:0] rs_val, rt_val, imm;
        logic [4:0]  rs, rt;
        logic        alusrc;
        logic [3:0]  af;
        logic        mem_rw;
        logic [4:0]  mem_rd;
        logic [31:0] mem_res;
        logic        wb_rw;
        logic [4:0]  wb_rd;
        logic [31:0] wb_res;
        logic [31:0] exp_a, exp_b;
    } vec_t;

    instr_t m;
    int n_checks = 0;
    int n_pass = 0;

    function automatic instr_t empty_slot();
        instr_t e;
        e = '{v: 1'b0, rw: 1'b0, mr: 1'b0, rd: 5'd0, rs: 5'd0, rt: 5'd0,
              rsv: 32'd0, rtv: 32'd0, imm: 32'd0, af: 4'd0, i: 1'b0, src: 1'b0};
        return e;
    endfunction

    // The newest producer wins: MEM is younger than WB; r0 is hard-wired
    function automatic logic [31:0] operand(input logic [4:0] idx, input logic [31:0] regval);
        if (idx == 5'd0) return regval;
        if (bus.mem_regwrite && bus.mem_rd == idx) return bus.mem_result;
        if (bus.wb_regwrite && bus.wb_rd == idx) return bus.wb_result;
        return regval;
    endfunction

    function automatic logic model_hazard();
        logic rs_dep, rt_dep;
        rs_dep = (m.rd == bus.id_rs);
        rt_dep = (m.rd == bus.id_rt) && !bus.id_alusrc;
        return m.v && m.mr && bus.id_valid && m.rd != 5'd0 && (rs_dep || rt_dep);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    endtask

    task automatic check_all(input string tag);
        logic [31:0] rt_op;
        rt_op = operand(m.rt, m.rtv);
        chk({tag, ".alu_a"}, bus.alu_a, operand(m.rs, m.rsv));
        chk({tag, ".alu_b"}, bus.alu_b, m.src ? m.imm : rt_op);
        chk({tag, ".store"}, bus.ex_store_data, rt_op);
        chk({tag, ".alu_af"}, 32'(bus.alu_af), 32'(m.af));
        chk({tag, ".alu_i"}, 32'(bus.alu_i), 32'(m.i));
        chk({tag, ".ex_rd"}, 32'(bus.ex_rd), 32'(m.rd));
        chk({tag, ".ex_valid"}, 32'(bus.ex_valid), 32'(m.v));
        chk({tag, ".ex_regwrite"}, 32'(bus.ex_regwrite), 32'(m.rw));
        chk({tag, ".ex_memread"}, 32'(bus.ex_memread), 32'(m.mr));
        chk({tag, ".hazard"}, 32'(bus.load_use_hazard), 32'(model_hazard()));
    endtask

    // Advance one clock and move the model by the same priority rules
    task automatic tick();
        instr_t nxt;
        logic haz;
        haz = model_hazard();
        nxt = m;
        if (!bus.stall) begin
            if (bus.flush || haz) begin
                nxt = empty_slot();
            end else begin
                nxt.v   = bus.id_valid;
                nxt.rw  = bus.id_regwrite && bus.id_valid;
                nxt.mr  = bus.id_memread && bus.id_valid;
                nxt.rd  = bus.id_rd;
                nxt.rs  = bus.id_rs;
                nxt.rt  = bus.id_rt;
                nxt.rsv = bus.id_rs_val;
                nxt.rtv = bus.id_rt_val;
                nxt.imm = bus.id_imm;
                nxt.af  = bus.id_af;
                nxt.i   = bus.id_i;
                nxt.src = bus.id_alusrc;
            end
        end
        @(posedge clk);
        m = nxt;
        #1;
    endtask

    task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                            input logic [4:0] rd, input logic [31:0] rsv, input logic [31:0] rtv,
                            input logic [31:0] imm, input logic [3:0] af, input logic src,
                            input logic rw, input logic mr);
        bus.id_valid    = v;
        bus.id_rs       = rs;
        bus.id_rt       = rt;
        bus.id_rd       = rd;
        bus.id_rs_val   = rsv;
        bus.id_rt_val   = rtv;
        bus.id_imm      = imm;
        bus.id_af       = af;
        bus.id_i        = src;
        bus.id_alusrc   = src;
        bus.id_regwrite = rw;
        bus.id_memread  = mr;
    endtask

    task automatic set_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                           input logic wrw, input logic [4:0] wrd, input logic [31:0] wres);
        bus.mem_regwrite = mrw;
        bus.mem_rd       = mrd;
        bus.mem_result   = mres;
        bus.wb_regwrite  = wrw;
        bus.wb_rd        = wrd;
        bus.wb_result    = wres;
    endtask

    vec_t vecs[6];

    initial begin
        vecs[0] = '{32'h10, 32'h20, 32'h0, 5'd1, 5'd2, 1'b0, 4'h0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'h20};
        vecs[1] = '{32'h10, 32'h20, 32'hFFFF_FFFC, 5'd1, 5'd2, 1'b1, 4'h2, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 32'h0, 32'h10, 32'hFFFF_FFFC};
        vecs[2] = '{32'h1, 32'h2, 32'h0, 5'd5, 5'd5, 1'b0, 4'h3, 1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hAAAA, 32'hAAAA};
        vecs[3] = '{32'h1, 32'h2, 32'h0, 5'd5, 5'd5, 1'b0, 4'h4, 1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB, 32'hBBBB, 32'hBBBB};
        vecs[4] = '{32'h11, 32'h22, 32'h0, 5'd0, 5'd0, 1'b0, 4'h5, 1'b1, 5'd0, 32'hAAAA, 1'b1, 5'd0, 32'hBBBB, 32'h11, 32'h22};
        vecs[5] = '{32'h1, 32'h2, 32'h0, 5'd3, 5'd4, 1'b0, 4'h6, 1'b1, 5'd4, 32'h1234, 1'b1, 5'd3, 32'h5678, 32'h5678, 32'h1234};

        bus.stall = 1'b0;
        bus.flush = 1'b0;
        drive_id(1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 32'd0, 32'd0, 4'd0, 1'b0, 1'b0, 1'b0);
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        m = empty_slot();
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        check_all("reset");

        foreach (vecs[k]) begin
            drive_id(1'b1, vecs[k].rs, vecs[k].rt, 5'd9, vecs[k].rs_val, vecs[k].rt_val,
                     vecs[k].imm, vecs[k].af, vecs[k].alusrc, 1'b1, 1'b0);
            set_fwd(vecs[k].mem_rw, vecs[k].mem_rd, vecs[k].mem_res,
                    vecs[k].wb_rw, vecs[k].wb_rd, vecs[k].wb_res);
            tick();
            chk($sformatf("vec%0d.a", k), bus.alu_a, vecs[k].exp_a);
            chk($sformatf("vec%0d.b", k), bus.alu_b, vecs[k].exp_b);
            chk($sformatf("vec%0d.af", k), 32'(bus.alu_af), 32'(vecs[k].af));
            check_all($sformatf("vec%0d", k));
        end

        // Load-use: load to r8 followed by a consumer of r8
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        drive_id(1'b1, 5'd1, 5'd2, 5'd8, 32'h40, 32'h0, 32'h4, 4'h0, 1'b1, 1'b1, 1'b1);
        tick();
        drive_id(1'b1, 5'd8, 5'd3, 5'd10, 32'h99, 32'h33, 32'h0, 4'h1, 1'b0, 1'b1, 1'b0);
        #1 chk("lu.hazard_high", 32'(bus.load_use_hazard), 32'd1);
        tick();
        chk("lu.bubble_valid", 32'(bus.ex_valid), 32'd0);
        chk("lu.bubble_rw", 32'(bus.ex_regwrite), 32'd0);
        chk("lu.hazard_low", 32'(bus.load_use_hazard), 32'd0);
        tick();
        chk("lu.reload_valid", 32'(bus.ex_valid), 32'd1);
        chk("lu.reload_a", bus.alu_a, 32'h99);
        check_all("lu");

        // Stall beats flush and new decode values; forwarding still live
        bus.stall = 1'b1;
        bus.flush = 1'b1;
        drive_id(1'b1, 5'd12, 5'd13, 5'd14, 32'h5555, 32'h6666, 32'h7, 4'hF, 1'b1, 1'b1, 1'b1);
        tick();
        chk("stall.hold_a", bus.alu_a, 32'h99);
        chk("stall.hold_valid", 32'(bus.ex_valid), 32'd1);
        check_all("stall");
        set_fwd(1'b1, 5'd8, 32'hCAFE, 1'b0, 5'd0, 32'd0);
        #1 chk("stall.fwd_a", bus.alu_a, 32'hCAFE);
        tick();
        check_all("stall2");

        // Flush alone kills a valid writing instruction
        bus.stall = 1'b0;
        set_fwd(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
        tick();
        chk("flush.valid", 32'(bus.ex_valid), 32'd0);
        chk("flush.rw", 32'(bus.ex_regwrite), 32'd0);
        chk("flush.mr", 32'(bus.ex_memread), 32'd0);
        chk("flush.af", 32'(bus.alu_af), 32'd0);
        bus.flush = 1'b0;

        // Asynchronous reset mid-cycle with a valid instruction in EX
        drive_id(1'b1, 5'd3, 5'd4, 5'd6, 32'h77, 32'h88, 32'h0, 4'h2, 1'b0, 1'b1, 1'b0);
        tick();
        chk("arst.pre_valid", 32'(bus.ex_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        m = empty_slot();
        chk("arst.valid", 32'(bus.ex_valid), 32'd0);
        chk("arst.a", bus.alu_a, 32'd0);
        chk("arst.b", bus.alu_b, 32'd0);
        check_all("arst");
        rst_n = 1'b1;

        for (int c = 0; c < 400; c++) begin
            bus.stall = ($urandom_range(0, 99) < 15);
            bus.flush = ($urandom_range(0, 99) < 10);
            drive_id($urandom_range(0, 9) < 8, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), $urandom, $urandom, $urandom, 4'($urandom),
                     1'($urandom), 1'($urandom), 1'($urandom));
            set_fwd(1'($urandom), 5'($urandom_range(0, 7)), $urandom,
                    1'($urandom), 5'($urandom_range(0, 7)), $urandom);
            tick();
            check_all("rand");
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
